asym_fifo_ctrl: RTL and testbench
=================================

// Module: asym_fifo_ctrl
// PURPOSE
//  Single-clock width-converting FIFO controller (narrow in, wide out) driving an external asymmetric
//  dual-port RAM: port A = narrow write, port B = wide read, 1-cycle registered read, no read enable-to-data bypass.
//  Sits between a narrow valid/ready producer and a wide valid/ready consumer; owns pointers, flow control,
//  and a 2-entry output buffer that hides RAM read latency.
// PARAMETERS
//  WIDTH_IN   4     narrow write word width (RAM port A width)
//  WIDTH_OUT  16    wide read word width (RAM port B width); RATIO = WIDTH_OUT/WIDTH_IN, power of 2, >=1
//  DEPTH_IN   1024  RAM depth in narrow words, power of 2, multiple of RATIO; DEPTH_OUT = DEPTH_IN/RATIO
// PORTS
//  clk         in   1                       clock
//  rst_n       in   1                       reset, asynchronous, active-low
//  in_valid    in   1                       narrow word offered
//  in_ready    out  1                       narrow word accepted when in_valid & in_ready
//  in_data     in   WIDTH_IN                narrow data
//  out_valid   out  1                       wide word available
//  out_ready   in   1                       wide word consumed when out_valid & out_ready
//  out_data    out  WIDTH_OUT               wide data
//  fill_level  out  $clog2(DEPTH_IN+2*RATIO+1)  narrow words held (RAM + output buffer)
//  ram_wea     out  1                       RAM port A write enable (ena tied to wea)
//  ram_addra   out  $clog2(DEPTH_IN)        RAM port A narrow address
//  ram_dina    out  WIDTH_IN                RAM port A write data
//  ram_enb     out  1                       RAM port B read enable
//  ram_addrb   out  $clog2(DEPTH_OUT)       RAM port B wide address
//  ram_doutb   in   WIDTH_OUT               RAM port B read data, valid cycle after ram_enb
// BEHAVIOUR
//  - Reset: all pointers, counters, buffer 0; in_ready=1, out_valid=0, out_data=0, fill_level=0, ram_wea=0, ram_enb=0.
//  - Pointers: wr_ptr (narrow, $clog2(DEPTH_IN)+1 bits), rd_ptr (wide, $clog2(DEPTH_OUT)+1 bits); MSB = wrap bit,
//    addresses = pointer LSBs, natural wrap DEPTH-1 -> 0.
//  - Write: accept -> ram_wea=1, ram_addra=wr_ptr, ram_dina=in_data combinationally same cycle; wr_ptr++.
//  - Packing: narrow word k of a wide word lands at bits [(k+1)*WIDTH_IN-1 -: WIDTH_IN]; first written = LSBs.
//  - ram_used = wr_ptr - {rd_ptr, log2(RATIO) zeros} (narrow words in RAM not yet read-issued).
//  - in_ready = (ram_used < DEPTH_IN); registered-free combinational from pointers, no in_valid dependency.
//  - Read issue: ram_enb=1 when ram_used >= RATIO and (buf_cnt + inflight - pop) < 2; ram_addrb=rd_ptr; rd_ptr++;
//    inflight flag set; data captured from ram_doutb next cycle into buffer tail. Partial wide words never issued.
//  - Output buffer: 2-entry FIFO, head drives out_data/out_valid (registered); pop on out_valid & out_ready.
//  - Latency: write of the RATIO-th narrow word in cycle N -> ram_enb in N+1 -> out_valid in N+2.
//  - Throughput: sustained 1 wide word/cycle on read side; 1 narrow word/cycle write; no bubbles with out_ready=1.
//  - Capacity: DEPTH_IN + 2*RATIO narrow words; fill_level = ram_used + RATIO*(buf_cnt + inflight).
//  - Simultaneous write + read issue at same RAM region: legal; read issue only covers complete, already-written
//    words (write lands at edge end of N, read issued >= N+1), so no read-during-write hazard.
//  - Simultaneous pop + capture: buffer count unchanged, order preserved.
//  - Reset asserted mid-operation: all contents discarded immediately; outputs to reset values asynchronously.
// CONFIGURATION
//  ASYM_FIFO_FLUSH_EN defined: adds input port 'flush' (1 bit). flush=1 for a cycle -> next edge clears pointers,
//    buffer, inflight (in-flight RAM data discarded); during flush cycle in_ready=0, ram_enb=0, no writes;
//    out_valid=0 and fill_level=0 from next cycle.
//  Not defined: no 'flush' port; contents cleared only by rst_n.
// TESTING
//  1 Reset: rst_n low mid-traffic -> in_ready=1, out_valid=0, fill_level=0, ram_wea=ram_enb=0 immediately.
//  2 Pack (defaults): write 0x1,0x2,0x3,0x4 back-to-back, out_ready=1 -> out_data=0x4321 two cycles after 4th accept.
//  3 Partial: write 3 words -> out_valid stays 0, fill_level=3, ram_enb never asserted.
//  4 Full: out_ready=0, in_valid=1 continuously -> exactly 1032 accepts, then in_ready=0, fill_level=1032;
//    one pop -> in_ready=1 within 2 cycles, 4 more accepts.
//  5 Stream/wrap: 4000 incrementing narrow words, out_ready=1 -> 1000 wide words in order, one per 4 cycles,
//    no gaps after first; pointers wrap twice, data intact.
//  6 Backpressure: random out_ready (50%) and in_valid (70%) for 10000 words -> scoreboard: no loss, no dup;
//    with ASYM_FIFO_FLUSH_EN, flush mid-stream -> out_valid=0, fill_level=0 next cycle, post-flush data correct.

Source files
------------

// File: rtl/asym_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// asym_fifo_ctrl
//
// Single-clock width-converting FIFO controller, narrow words in and wide
// words out. It drives an external asymmetric dual-port RAM. Port A is the
// narrow write port. Port B is the wide read port, and its read data is
// registered, so it appears one cycle after ram_enb. The controller owns the
// write and read pointers and the flow control. It also owns a 2-entry output
// buffer, which hides the RAM read latency so the read side can sustain one
// wide word per cycle.
//
// Narrow word k of a wide word lands in bits [(k+1)*WIDTH_IN-1 -: WIDTH_IN].
// The first narrow word written therefore ends up in the LSBs. This packing
// comes purely from the addressing: a wide word at address a is made of the
// narrow words at addresses a*RATIO .. a*RATIO+RATIO-1.
//
// Optional feature: define ASYM_FIFO_FLUSH_EN to add a synchronous 'flush'
// input. Holding flush high for one cycle empties the FIFO at the next edge.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     narrow producer handshake, in_data narrow payload
//   out_valid/out_ready   wide consumer handshake, out_data wide payload
//   fill_level            narrow words held (RAM + in-flight read + buffer)
//   ram_wea/addra/dina    RAM port A (narrow write, enable tied to write)
//   ram_enb/addrb/doutb   RAM port B (wide read, doutb valid cycle after enb)
//   flush                 only with ASYM_FIFO_FLUSH_EN
// -----------------------------------------------------------------------------
module asym_fifo_ctrl #(
  parameter int WIDTH_IN  = 4,
  parameter int WIDTH_OUT = 16,
  parameter int DEPTH_IN  = 1024,
  localparam int RATIO     = WIDTH_OUT / WIDTH_IN,
  localparam int RLOG      = $clog2(RATIO),
  localparam int DEPTH_OUT = DEPTH_IN / RATIO,
  localparam int AW_IN     = $clog2(DEPTH_IN),
  localparam int AW_OUT    = $clog2(DEPTH_OUT),
  localparam int FLW       = $clog2(DEPTH_IN + 2 * RATIO + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef ASYM_FIFO_FLUSH_EN
  input  logic                 flush,
`endif
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH_IN-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_OUT-1:0] out_data,
  output logic [FLW-1:0]       fill_level,
  output logic                 ram_wea,
  output logic [AW_IN-1:0]     ram_addra,
  output logic [WIDTH_IN-1:0]  ram_dina,
  output logic                 ram_enb,
  output logic [AW_OUT-1:0]    ram_addrb,
  input  logic [WIDTH_OUT-1:0] ram_doutb
);

  localparam int PW_IN = AW_IN + 1;

  logic [AW_IN:0]                wrPtr;
  logic [AW_OUT:0]               rdPtr;
  logic [AW_IN:0]                rdPtrNarrow;
  logic [AW_IN:0]                ramUsed;
  logic                          inflight;
  logic [1:0]                    bufCnt;
  logic                          bufHead;
  logic                          bufTail;
  logic [1:0][WIDTH_OUT-1:0]     bufMem;
  logic [2:0]                    occupancy;
  logic                          accept;
  logic                          issue;
  logic                          pop;
  logic                          flushReq;

  // Without the flush feature the clear request is tied off. The rest of the
  // logic then stays identical in both builds.
`ifdef ASYM_FIFO_FLUSH_EN
  assign flushReq = flush;
`else
  assign flushReq = 1'b0;
`endif

  // Pointer arithmetic. The read pointer counts wide words, so it is scaled
  // up to narrow units before the subtraction. Both pointers carry one extra
  // wrap bit. Because of that, the difference is exact across wrap-around,
  // and a completely full RAM (DEPTH_IN words) is distinguishable from empty.
  always_comb begin
    rdPtrNarrow = PW_IN'(rdPtr) << RLOG;
    ramUsed     = wrPtr - rdPtrNarrow;
  end

  // Handshakes and the read-issue decision.
  // Write acceptance depends only on RAM space, never on in_valid. Acceptance
  // is also gated by rst_n, so no write strobe can escape while reset is held.
  // A read is issued only when a complete wide word sits in the RAM and the
  // buffer can still absorb the returning data. The occupancy check counts
  // the word already in flight. It also credits a pop happening this cycle;
  // that credit is what keeps the read side streaming at one word per cycle.
  always_comb begin
    in_ready  = (ramUsed < PW_IN'(DEPTH_IN)) && !flushReq;
    accept    = in_valid && in_ready && rst_n;
    out_valid = (bufCnt != 2'd0);
    out_data  = bufMem[bufHead];
    pop       = out_valid && out_ready;
    occupancy = 3'(bufCnt) + 3'(inflight) - 3'(pop);
    issue     = (ramUsed >= PW_IN'(RATIO)) && (occupancy < 3'd2) && !flushReq;
    bufTail   = bufCnt[0] ? ~bufHead : bufHead;
  end

  // RAM port drive. The write goes straight through in the accept cycle. The
  // read address is the wide read pointer.
  always_comb begin
    ram_wea   = accept;
    ram_addra = wrPtr[AW_IN-1:0];
    ram_dina  = in_data;
    ram_enb   = issue;
    ram_addrb = rdPtr[AW_OUT-1:0];
  end

  // Fill level counts every narrow word the FIFO is responsible for: words
  // still in the RAM, the wide word being read, and the buffered wide words.
  always_comb begin
    fill_level = FLW'(ramUsed) + FLW'(RATIO) * (FLW'(bufCnt) + FLW'(inflight));
  end

  // Pointer, in-flight and output buffer state.
  // Returning read data is written at the tail slot. The tail is computed
  // from the count before any pop this cycle. That lets a simultaneous pop
  // and capture keep the count unchanged while preserving order. Reset and
  // flush both discard everything, including a read that is still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      inflight <= 1'b0;
      bufCnt   <= 2'd0;
      bufHead  <= 1'b0;
      bufMem   <= '0;
    end else if (flushReq) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      inflight <= 1'b0;
      bufCnt   <= 2'd0;
      bufHead  <= 1'b0;
      bufMem   <= '0;
    end else begin
      if (accept) begin
        wrPtr <= wrPtr + PW_IN'(1);
      end
      if (issue) begin
        rdPtr <= rdPtr + (AW_OUT + 1)'(1);
      end
      inflight <= issue;
      if (inflight) begin
        bufMem[bufTail] <= ram_doutb;
      end
      if (pop) begin
        bufHead <= ~bufHead;
      end
      bufCnt <= bufCnt + 2'(inflight) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_asym_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_asym_fifo_ctrl
//
// Self-checking bench for asym_fifo_ctrl with default parameters. It contains
// a behavioural model of the asymmetric RAM: narrow writes, and registered
// wide reads. A negedge monitor packs every accepted narrow word into the
// expected wide word and pushes it onto a queue. It pops and compares the
// queue whenever the DUT hands out a wide word. The main sequence covers
// reset, packing latency, partial words, full/capacity behaviour, streaming
// with pointer wrap, a mid-traffic reset and random backpressure. The flush
// sequence is built only when ASYM_FIFO_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_asym_fifo_ctrl;

  localparam int WIDTH_IN  = 4;
  localparam int WIDTH_OUT = 16;
  localparam int DEPTH_IN  = 1024;
  localparam int RATIO     = WIDTH_OUT / WIDTH_IN;
  localparam int DEPTH_OUT = DEPTH_IN / RATIO;
  localparam int AW_IN     = $clog2(DEPTH_IN);
  localparam int AW_OUT    = $clog2(DEPTH_OUT);
  localparam int FLW       = $clog2(DEPTH_IN + 2 * RATIO + 1);
  localparam int CAPACITY  = DEPTH_IN + 2 * RATIO;

  logic                 clk = 1'b0;
  logic                 rstN = 1'b0;
  logic                 flushTb = 1'b0;
  logic                 inValid = 1'b0;
  logic                 outReady = 1'b0;
  logic [WIDTH_IN-1:0]  inData = '0;
  logic                 inReady;
  logic                 outValid;
  logic [WIDTH_OUT-1:0] outData;
  logic [FLW-1:0]       fillLevel;
  logic                 ramWea;
  logic [AW_IN-1:0]     ramAddra;
  logic [WIDTH_IN-1:0]  ramDina;
  logic                 ramEnb;
  logic [AW_OUT-1:0]    ramAddrb;
  logic [WIDTH_OUT-1:0] ramDoutb = '0;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  asym_fifo_ctrl #(
    .WIDTH_IN (WIDTH_IN),
    .WIDTH_OUT(WIDTH_OUT),
    .DEPTH_IN (DEPTH_IN)
  ) dut (
    .clk       (clk),
    .rst_n     (rstN),
`ifdef ASYM_FIFO_FLUSH_EN
    .flush     (flushTb),
`endif
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_data   (inData),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_data  (outData),
    .fill_level(fillLevel),
    .ram_wea   (ramWea),
    .ram_addra (ramAddra),
    .ram_dina  (ramDina),
    .ram_enb   (ramEnb),
    .ram_addrb (ramAddrb),
    .ram_doutb (ramDoutb)
  );

  // Asymmetric RAM model. A wide word at address a is assembled from narrow
  // words a*RATIO .. a*RATIO+RATIO-1, with the lowest address in the LSBs.
  logic [WIDTH_IN-1:0] ramMem [DEPTH_IN];

  always @(posedge clk) begin
    if (ramWea) ramMem[ramAddra] <= ramDina;
    if (ramEnb) begin
      for (int i = 0; i < RATIO; i++) begin
        ramDoutb[i*WIDTH_IN +: WIDTH_IN] <= ramMem[AW_IN'(int'(ramAddrb) * RATIO + i)];
      end
    end
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  // Accepted narrow words are packed into expected wide words. Every wide
  // pop is compared in order. Reset or flush discards the expected contents,
  // just as the DUT does. During streaming, the spacing between pops is
  // tracked as well.
  logic [WIDTH_OUT-1:0] sbQueue[$];
  logic [WIDTH_OUT-1:0] packWord = '0;
  int  packCnt = 0;
  int  acceptCount = 0;
  int  popCount = 0;
  int  pushSinceClear = 0;
  int  popSinceClear = 0;
  int  cycleCount = 0;
  int  lastPopCycle = 0;
  int  gapErrs = 0;
  int  streamPops = 0;
  bit  havePrev = 1'b0;
  bit  streamMode = 1'b0;

  always @(negedge clk) begin
    cycleCount++;
    if (!rstN || flushTb) begin
      sbQueue.delete();
      packCnt = 0;
      packWord = '0;
      pushSinceClear = 0;
      popSinceClear = 0;
      havePrev = 1'b0;
    end else begin
      if (inValid && inReady) begin
        packWord[packCnt*WIDTH_IN +: WIDTH_IN] = inData;
        packCnt++;
        acceptCount++;
        if (packCnt == RATIO) begin
          sbQueue.push_back(packWord);
          pushSinceClear++;
          packCnt = 0;
          packWord = '0;
        end
      end
      if (outValid && outReady) begin
        popCount++;
        popSinceClear++;
        if (sbQueue.size() == 0) begin
          checkOutput("sbUnderflow", 64'(popSinceClear), 64'(pushSinceClear));
        end else begin
          checkOutput("sbData", 64'(outData), 64'(sbQueue.pop_front()));
        end
        if (streamMode) begin
          if (havePrev && (cycleCount - lastPopCycle != RATIO)) gapErrs++;
          havePrev = 1'b1;
          lastPopCycle = cycleCount;
          streamPops++;
        end
      end
    end
  end

  // Drives random or continuous traffic until numWords narrow words have
  // been accepted. It then drops in_valid right after the final accept edge.
  task automatic applyStimulus(input int numWords, input int validPct,
                               input int readyPct, input bit randomData);
    int sent = 0;
    int guard = 0;
    while (sent < numWords && guard < 40000) begin
      @(posedge clk); #1;
      inValid  = ($urandom_range(0, 99) < validPct);
      outReady = ($urandom_range(0, 99) < readyPct);
      inData   = randomData ? WIDTH_IN'($urandom) : WIDTH_IN'(sent);
      @(negedge clk);
      if (inValid && inReady) sent++;
      guard++;
    end
    if (sent < numWords) checkOutput("stimTimeout", 64'(sent), 64'(numWords));
    @(posedge clk); #1;
    inValid = 1'b0;
  endtask

  // Empties the FIFO with out_ready held high, within a cycle budget.
  task automatic waitDrain(input int limit);
    int n = 0;
    inValid  = 1'b0;
    outReady = 1'b1;
    while ((fillLevel != '0 || outValid) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drainFill", 64'(fillLevel), 64'(0));
    checkOutput("drainQueue", 64'(sbQueue.size()), 64'(0));
  endtask

  initial begin
    #400_000_000;
    $display("[TB] FAIL watchdog: observed still running, required finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accStart;
    int popStart;
    int n;
    bit enbSeen;
    bit sawReady;

    // Reset state while rst_n is held low.
    #2;
    checkOutput("rstInReady", 64'(inReady), 64'(1));
    checkOutput("rstOutValid", 64'(outValid), 64'(0));
    checkOutput("rstOutData", 64'(outData), 64'(0));
    checkOutput("rstFill", 64'(fillLevel), 64'(0));
    checkOutput("rstWea", 64'(ramWea), 64'(0));
    checkOutput("rstEnb", 64'(ramEnb), 64'(0));
    @(negedge clk);
    rstN = 1'b1;

    // Pack 1,2,3,4: read issued the cycle after the 4th accept, data two later.
    outReady = 1'b1;
    for (int k = 0; k < RATIO; k++) begin
      @(posedge clk); #1;
      inValid = 1'b1;
      inData  = WIDTH_IN'(k + 1);
      if (k == 1) begin
        #1;
        checkOutput("packWea", 64'(ramWea), 64'(1));
        checkOutput("packAddra", 64'(ramAddra), 64'(1));
        checkOutput("packDina", 64'(ramDina), 64'(2));
      end
    end
    @(posedge clk); #1;
    inValid = 1'b0;
    checkOutput("packEnb", 64'(ramEnb), 64'(1));
    checkOutput("packAddrb", 64'(ramAddrb), 64'(0));
    checkOutput("packFill", 64'(fillLevel), 64'(4));
    @(posedge clk); #1;
    checkOutput("packEarlyValid", 64'(outValid), 64'(0));
    checkOutput("packInflightFill", 64'(fillLevel), 64'(4));
    @(posedge clk); #1;
    checkOutput("packValid", 64'(outValid), 64'(1));
    checkOutput("packData", 64'(outData), 64'(16'h4321));
    repeat (3) @(posedge clk);
    #1;

    // Partial wide word: three narrow words must never trigger a read.
    applyStimulus(3, 100, 100, 1'b0);
    enbSeen = ramEnb;
    repeat (6) begin
      @(posedge clk); #1;
      if (ramEnb) enbSeen = 1'b1;
    end
    checkOutput("partialEnb", 64'(enbSeen), 64'(0));
    checkOutput("partialValid", 64'(outValid), 64'(0));
    checkOutput("partialFill", 64'(fillLevel), 64'(3));
    applyStimulus(1, 100, 100, 1'b0);
    waitDrain(50);

    // Full: no consumer, continuous producer until in_ready drops.
    outReady = 1'b0;
    accStart = acceptCount;
    n = 0;
    @(posedge clk); #1;
    inValid = 1'b1;
    while (inReady && n < 1500) begin
      @(posedge clk); #1;
      inData = inData + WIDTH_IN'(1);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("fullAccepts", 64'(acceptCount - accStart), 64'(CAPACITY));
    checkOutput("fullInReady", 64'(inReady), 64'(0));
    checkOutput("fullFill", 64'(fillLevel), 64'(CAPACITY));
    outReady = 1'b1;
    @(posedge clk); #1;
    outReady = 1'b0;
    sawReady = inReady;
    @(posedge clk); #1;
    sawReady = sawReady | inReady;
    checkOutput("fullReadyAfterPop", 64'(sawReady), 64'(1));
    repeat (6) @(posedge clk);
    #1;
    checkOutput("fullRefillAccepts", 64'(acceptCount - accStart), 64'(CAPACITY + RATIO));
    checkOutput("fullRefillFill", 64'(fillLevel), 64'(CAPACITY));
    inValid = 1'b0;
    waitDrain(3000);

    // Streaming with pointer wrap: one wide word every RATIO cycles.
    streamMode = 1'b1;
    applyStimulus(4000, 100, 100, 1'b0);
    waitDrain(100);
    streamMode = 1'b0;
    checkOutput("streamPops", 64'(streamPops), 64'(1000));
    checkOutput("streamGaps", 64'(gapErrs), 64'(0));

    // Reset mid-traffic: outputs return to reset values immediately.
    applyStimulus(20, 100, 0, 1'b1);
    inValid = 1'b1;
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midRstInReady", 64'(inReady), 64'(1));
    checkOutput("midRstOutValid", 64'(outValid), 64'(0));
    checkOutput("midRstFill", 64'(fillLevel), 64'(0));
    checkOutput("midRstWea", 64'(ramWea), 64'(0));
    checkOutput("midRstEnb", 64'(ramEnb), 64'(0));
    inValid = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstFill", 64'(fillLevel), 64'(0));

    // Random backpressure on both sides.
    popStart = popCount;
    applyStimulus(10000, 70, 50, 1'b1);
    waitDrain(3000);
    checkOutput("bpPops", 64'(popCount - popStart), 64'(2500));

`ifdef ASYM_FIFO_FLUSH_EN
    // Flush mid-stream, then verify that fresh data flows correctly.
    applyStimulus(10, 100, 0, 1'b1);
    inValid = 1'b1;
    flushTb = 1'b1;
    #1;
    checkOutput("flushInReady", 64'(inReady), 64'(0));
    checkOutput("flushWea", 64'(ramWea), 64'(0));
    checkOutput("flushEnb", 64'(ramEnb), 64'(0));
    @(posedge clk); #1;
    flushTb = 1'b0;
    inValid = 1'b0;
    checkOutput("flushOutValid", 64'(outValid), 64'(0));
    checkOutput("flushFill", 64'(fillLevel), 64'(0));
    popStart = popCount;
    applyStimulus(12, 100, 100, 1'b1);
    waitDrain(100);
    checkOutput("flushPostPops", 64'(popCount - popStart), 64'(3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
